// File: rtl/pulse_stretch_of_verifla.sv
// Stretches one-cycle strobes into programmable-width high levels separated by a fixed low gap.
// Optional retrigger mode (extend the running pulse instead of queueing) is enabled by PULSE_STRETCH_RETRIGGER_EN.
module pulse_stretch_of_verifla #(
  parameter int WIDTH_BITS = 8,
  parameter int MIN_GAP    = 2,
  parameter int PEND_BITS  = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  pulse_in,
  input  logic [WIDTH_BITS-1:0] width,
  output logic                  level_out,
  output logic                  busy,
  output logic [PEND_BITS-1:0]  pending,
  output logic                  overflow
);

  typedef enum logic [1:0] {IDLE, HIGH, GAP} state_t;

  localparam logic [PEND_BITS-1:0] PEND_MAX = '1;
  localparam logic [7:0]           GAP_LOAD = 8'(MIN_GAP);

  state_t                state_q, state_d;
  logic [WIDTH_BITS-1:0] cnt_q, cnt_d;
  logic [7:0]            gap_q, gap_d;
  logic [PEND_BITS-1:0]  pend_q, pend_d;
  logic                  level_q, level_d;
  logic                  busy_q, busy_d;
  logic                  ovf_q, ovf_d;
  logic [WIDTH_BITS-1:0] widthEff;
  logic                  queueReq;
  logic                  consumeReq;

  assign widthEff = (width == '0) ? WIDTH_BITS'(1) : width;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      gap_q   <= '0;
      pend_q  <= '0;
      level_q <= 1'b0;
      busy_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      gap_q   <= gap_d;
      pend_q  <= pend_d;
      level_q <= level_d;
      busy_q  <= busy_d;
      ovf_q   <= ovf_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    gap_d      = gap_q;
    pend_d     = pend_q;
    ovf_d      = 1'b0;
    queueReq   = 1'b0;
    consumeReq = 1'b0;

    case (state_q)
      IDLE: begin
        if (pulse_in) begin
          state_d = HIGH;
          cnt_d   = widthEff;
        end
      end
      HIGH: begin
`ifdef PULSE_STRETCH_RETRIGGER_EN
        if (pulse_in) begin
          cnt_d = widthEff;
        end else if (cnt_q <= WIDTH_BITS'(1)) begin
          state_d = GAP;
          gap_d   = GAP_LOAD;
        end else begin
          cnt_d = cnt_q - WIDTH_BITS'(1);
        end
`else
        queueReq = pulse_in;
        if (cnt_q <= WIDTH_BITS'(1)) begin
          state_d = GAP;
          gap_d   = GAP_LOAD;
        end else begin
          cnt_d = cnt_q - WIDTH_BITS'(1);
        end
`endif
      end
      GAP: begin
        // The queue always wins the slot; a simultaneous new strobe goes to the back.
        if (gap_q <= 8'd1) begin
          if (pend_q != '0) begin
            consumeReq = 1'b1;
            queueReq   = pulse_in;
            state_d    = HIGH;
            cnt_d      = widthEff;
          end else if (pulse_in) begin
            state_d = HIGH;
            cnt_d   = widthEff;
          end else begin
            state_d = IDLE;
          end
        end else begin
          gap_d    = gap_q - 8'd1;
          queueReq = pulse_in;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (queueReq && !consumeReq) begin
      if (pend_q == PEND_MAX) begin
        ovf_d = 1'b1;
      end else begin
        pend_d = pend_q + PEND_BITS'(1);
      end
    end else if (consumeReq && !queueReq) begin
      pend_d = pend_q - PEND_BITS'(1);
    end

    level_d = (state_d == HIGH);
    busy_d  = (state_d != IDLE) || (pend_d != '0);
  end

  assign level_out = level_q;
  assign busy      = busy_q;
  assign pending   = pend_q;
  assign overflow  = ovf_q;

endmodule

// File: tb/tb_pulse_stretch_of_verifla.sv
// Self-checking bench for pulse_stretch_of_verifla using an interval-based reference model.
// Tracks the PULSE_STRETCH_RETRIGGER_EN build option so either build is checked.
module tb_pulse_stretch_of_verifla;

  localparam int WB   = 8;
  localparam int MG   = 2;
  localparam int PB   = 2;
  localparam int PMAX = (1 << PB) - 1;

  logic          clk = 1'b0;
  logic          reset;
  logic          pulse_in;
  logic [WB-1:0] width;
  logic          level_out;
  logic          busy;
  logic [PB-1:0] pending;
  logic          overflow;

  int checks = 0;
  int fails  = 0;

  // Model state: current/last pulse occupies cycles mHiStart..mHiEnd, gap follows for MG cycles.
  int   mT;
  int   mHiStart;
  int   mHiEnd;
  int   mPend;
  logic mOvf;

  pulse_stretch_of_verifla #(.WIDTH_BITS(WB), .MIN_GAP(MG), .PEND_BITS(PB)) dut (
    .clk(clk), .reset(reset), .pulse_in(pulse_in), .width(width),
    .level_out(level_out), .busy(busy), .pending(pending), .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic modelReset();
    mT       = 0;
    mHiStart = -100;
    mHiEnd   = -100;
    mPend    = 0;
    mOvf     = 1'b0;
  endtask

  // Advance the model across one clock edge with the inputs present during cycle mT.
  task automatic modelStep(input logic p, input int w);
    int t;
    int we;
    bit q;
    bit c;
    t  = mT;
    we = (w == 0) ? 1 : w;
    q  = 0;
    c  = 0;
    if (t >= mHiStart && t <= mHiEnd) begin
`ifdef PULSE_STRETCH_RETRIGGER_EN
      if (p) mHiEnd = t + we;
`else
      q = p;
`endif
    end else if (t > mHiEnd && t <= mHiEnd + MG) begin
      if (t == mHiEnd + MG && (mPend > 0 || p)) begin
        c = (mPend > 0);
        q = p && (mPend > 0);
        mHiStart = t + 1;
        mHiEnd   = t + we;
      end else begin
        q = p;
      end
    end else if (p) begin
      mHiStart = t + 1;
      mHiEnd   = t + we;
    end
    mOvf = 1'b0;
    if (q && !c) begin
      if (mPend == PMAX) mOvf = 1'b1;
      else mPend++;
    end else if (c && !q) begin
      mPend--;
    end
    mT = t + 1;
  endtask

  function automatic logic [PB+2:0] expVec();
    logic lvl;
    logic bsy;
    lvl = (mT >= mHiStart) && (mT <= mHiEnd);
    bsy = (mT <= mHiEnd + MG) || (mPend > 0);
    return {lvl, bsy, PB'(mPend), mOvf};
  endfunction

  task automatic applyReset();
    reset    = 1'b1;
    pulse_in = 1'b0;
    width    = '0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    modelReset();
  endtask

  task automatic cycleDrive(input logic p, input int w);
    @(negedge clk);
    pulse_in = p;
    width    = WB'(w);
    @(posedge clk);
    modelStep(p, w);
    #1;
  endtask

  task automatic test_reset();
    reset    = 1'b1;
    pulse_in = 1'b1;
    width    = 8'd5;
    #2;
    checks++;
    if ({level_out, busy, pending, overflow} !== '0)
      begin fails++; $display("[TB] FAIL reset_async: got %b required 0", {level_out, busy, pending, overflow}); end
    @(negedge clk);
    @(negedge clk);
    checks++;
    if ({level_out, busy, pending, overflow} !== '0)
      begin fails++; $display("[TB] FAIL reset_held: got %b required 0", {level_out, busy, pending, overflow}); end
    reset    = 1'b0;
    pulse_in = 1'b0;
    modelReset();
  endtask

  task automatic test_basic();
    int firstHigh = -1;
    int highCnt = 0;
    int busyLow = -1;
    int pendMax = 0;
    applyReset();
    for (int i = 0; i < 25; i++) begin
      cycleDrive(i == 10, 5);
      checks++;
      if ({level_out, busy, pending, overflow} !== expVec())
        begin fails++; $display("[TB] FAIL basic cycle %0d: got %b required %b", i + 1, {level_out, busy, pending, overflow}, expVec()); end
      if (level_out) begin highCnt++; if (firstHigh < 0) firstHigh = i + 1; end
      if (!busy && firstHigh >= 0 && busyLow < 0) busyLow = i + 1;
      if (int'(pending) > pendMax) pendMax = int'(pending);
    end
    checks++;
    if (firstHigh !== 11 || highCnt !== 5 || busyLow !== 18 || pendMax !== 0)
      begin fails++; $display("[TB] FAIL basic_shape: got first=%0d len=%0d busyLow=%0d pend=%0d required 11 5 18 0", firstHigh, highCnt, busyLow, pendMax); end
  endtask

  task automatic test_width_zero();
    int firstHigh = -1;
    int highCnt = 0;
    int busyLow = -1;
    applyReset();
    for (int i = 0; i < 12; i++) begin
      cycleDrive(i == 3, 0);
      checks++;
      if ({level_out, busy, pending, overflow} !== expVec())
        begin fails++; $display("[TB] FAIL width_zero cycle %0d: got %b required %b", i + 1, {level_out, busy, pending, overflow}, expVec()); end
      if (level_out) begin highCnt++; if (firstHigh < 0) firstHigh = i + 1; end
      if (!busy && firstHigh >= 0 && busyLow < 0) busyLow = i + 1;
    end
    checks++;
    if (firstHigh !== 4 || highCnt !== 1 || busyLow !== 7)
      begin fails++; $display("[TB] FAIL width_zero_shape: got first=%0d len=%0d busyLow=%0d required 4 1 7", firstHigh, highCnt, busyLow); end
  endtask

  task automatic test_queueing();
    int rises = 0;
    int pendMax = 0;
    int lastHigh = -1;
    logic prevLvl = 1'b0;
    applyReset();
    for (int i = 0; i < 30; i++) begin
      cycleDrive(i == 10 || i == 12 || i == 13, 3);
      checks++;
      if ({level_out, busy, pending, overflow} !== expVec())
        begin fails++; $display("[TB] FAIL queueing cycle %0d: got %b required %b", i + 1, {level_out, busy, pending, overflow}, expVec()); end
      if (level_out && !prevLvl) rises++;
      if (level_out) lastHigh = i + 1;
      prevLvl = level_out;
      if (int'(pending) > pendMax) pendMax = int'(pending);
    end
    checks++;
    if (rises !== 3 || pendMax !== 2 || lastHigh !== 23 || pending !== '0)
      begin fails++; $display("[TB] FAIL queueing_shape: got rises=%0d peak=%0d last=%0d pend=%0d required 3 2 23 0", rises, pendMax, lastHigh, pending); end
  endtask

  task automatic test_overflow();
    int rises = 0;
    int ovfCnt = 0;
    int pendMax = 0;
    logic prevLvl = 1'b0;
    applyReset();
    for (int i = 0; i < 100; i++) begin
      cycleDrive(i == 0 || (i >= 2 && i <= 6), 20);
      checks++;
      if ({level_out, busy, pending, overflow} !== expVec())
        begin fails++; $display("[TB] FAIL overflow cycle %0d: got %b required %b", i + 1, {level_out, busy, pending, overflow}, expVec()); end
      if (level_out && !prevLvl) rises++;
      prevLvl = level_out;
      if (overflow) ovfCnt++;
      if (int'(pending) > pendMax) pendMax = int'(pending);
    end
    checks++;
    if (rises !== 4 || ovfCnt !== 2 || pendMax !== PMAX)
      begin fails++; $display("[TB] FAIL overflow_shape: got pulses=%0d ovf=%0d peak=%0d required 4 2 %0d", rises, ovfCnt, pendMax, PMAX); end
  endtask

  task automatic test_reset_mid();
    int highCnt = 0;
    applyReset();
    cycleDrive(1'b1, 10);
    cycleDrive(1'b1, 10);
    cycleDrive(1'b0, 10);
    #2;
    reset = 1'b1;
    #1;
    checks++;
    if ({level_out, busy, pending} !== '0)
      begin fails++; $display("[TB] FAIL reset_mid_async: got %b required 0", {level_out, busy, pending}); end
    @(negedge clk);
    reset = 1'b0;
    modelReset();
    for (int i = 0; i < 16; i++) begin
      cycleDrive(i == 0, 10);
      checks++;
      if ({level_out, busy, pending, overflow} !== expVec())
        begin fails++; $display("[TB] FAIL reset_mid cycle %0d: got %b required %b", i + 1, {level_out, busy, pending, overflow}, expVec()); end
      if (level_out) highCnt++;
    end
    checks++;
    if (highCnt !== 10)
      begin fails++; $display("[TB] FAIL reset_mid_len: got %0d required 10", highCnt); end
  endtask

  task automatic test_retrigger();
    int rises = 0;
    int highCnt = 0;
    int firstHigh = -1;
    int expRises;
    int expHigh;
    logic prevLvl = 1'b0;
`ifdef PULSE_STRETCH_RETRIGGER_EN
    expRises = 1;
    expHigh  = 6;
`else
    expRises = 2;
    expHigh  = 8;
`endif
    applyReset();
    for (int i = 0; i < 28; i++) begin
      cycleDrive(i == 10 || i == 12, 4);
      checks++;
      if ({level_out, busy, pending, overflow} !== expVec())
        begin fails++; $display("[TB] FAIL retrigger cycle %0d: got %b required %b", i + 1, {level_out, busy, pending, overflow}, expVec()); end
      if (level_out && !prevLvl) rises++;
      if (level_out) begin highCnt++; if (firstHigh < 0) firstHigh = i + 1; end
      prevLvl = level_out;
    end
    checks++;
    if (rises !== expRises || highCnt !== expHigh || firstHigh !== 11)
      begin fails++; $display("[TB] FAIL retrigger_shape: got pulses=%0d high=%0d first=%0d required %0d %0d 11", rises, highCnt, firstHigh, expRises, expHigh); end
  endtask

  task automatic test_random();
    applyReset();
    for (int i = 0; i < 400; i++) begin
      cycleDrive($urandom_range(0, 9) < 4, int'($urandom_range(0, 6)));
      checks++;
      if ({level_out, busy, pending, overflow} !== expVec())
        begin fails++; $display("[TB] FAIL random cycle %0d: got %b required %b", i + 1, {level_out, busy, pending, overflow}, expVec()); end
    end
  endtask

  initial begin
    reset    = 1'b1;
    pulse_in = 1'b0;
    width    = '0;
    modelReset();
    test_reset();
    test_basic();
    test_width_zero();
    test_queueing();
    test_overflow();
    test_reset_mid();
    test_retrigger();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/pulse_stretch_of_verifla.md
Name: pulse_stretch_of_verifla

Overview:
- Inverse of the single-pulse detector: converts one-clock strobes into contiguous multi-cycle high levels of programmable width.
- Enforces a minimum low gap between output pulses, so a downstream single-pulse detector always re-arms between them.
- Strobes that arrive while a pulse is in progress are counted and replayed in order.
- Used to drive trigger/level inputs of the logic-analyzer core from one-cycle event strobes.

Parameters:
- WIDTH_BITS, 8, width of the width input and of the high-time down-counter.
- MIN_GAP, 2, number of forced low cycles after every output pulse; legal range 1..255.
- PEND_BITS, 2, width of the pending-strobe counter; saturates at 2^PEND_BITS-1.

Ports:
- clk  input  1  system clock; all logic on posedge.
- reset  input  1  asynchronous, active-high reset.
- pulse_in  input  1  strobe; every clk cycle it is high counts as one request.
- width  input  WIDTH_BITS  high time in cycles; 0 is treated as 1; sampled when a HIGH phase starts.
- level_out  output  1  stretched pulse (registered).
- busy  output  1  high when state != IDLE or pending != 0.
- pending  output  PEND_BITS  number of queued requests not yet started.
- overflow  output  1  one-cycle strobe: a request was dropped because pending was saturated.

Behaviour:
- Reset (asynchronous, active-high, takes effect immediately, including mid-pulse):
  - state = IDLE.
  - level_out, busy, overflow, pending and all counters = 0.
- FSM states: IDLE, HIGH, GAP. All outputs are registered.
- IDLE:
  - pulse_in=1 at edge k -> state HIGH; level_out=1 from edge k+1.
  - The high counter loads max(width,1) at that edge.
  - Latency is 1 cycle.
- HIGH:
  - level_out=1; the counter decrements each cycle.
  - level_out stays high for exactly max(width,1) cycles, then state GAP with level_out=0.
- GAP:
  - level_out=0 for exactly MIN_GAP cycles.
  - On the last GAP cycle, pending>0 or pulse_in=1 -> HIGH, with width re-sampled at that edge. Otherwise -> IDLE.
- Queueing:
  - pulse_in=1 in HIGH, or in GAP when it is not consumed on the last GAP cycle, increments pending.
  - Pending saturates. A request arriving at saturation is dropped and overflow=1 for the next cycle only.
- Simultaneous events:
  - A new request arriving on the same edge a pending request is consumed leaves pending unchanged.
  - Consumption always prefers the queue; the new request is queued.
- Back-to-back output pulses are always separated by exactly MIN_GAP low cycles.
- Changes on width during HIGH have no effect on the current pulse.

Optional Feature:
- Macro: PULSE_STRETCH_RETRIGGER_EN.
- When defined:
  - pulse_in=1 during HIGH reloads the high counter with max(width,1), extending the current pulse; pending is not incremented.
  - Requests in GAP still queue.
- When undefined:
  - Requests in HIGH queue as described under Behaviour.
  - The retrigger reload logic is not compiled.

Test Plan:
- Basic stretch: reset, width=5, MIN_GAP=2, one-cycle pulse_in at cycle 10 -> level_out high cycles 11..15, low from 16; busy low from cycle 18; pending stays 0.
- Width zero: width=0, single strobe -> level_out high exactly 1 cycle, then 2 low cycles, then IDLE.
- Queueing: width=3, strobes at cycles 10, 12 and 13 -> pulses at 11..13, 16..18 and 21..23 (gaps of exactly 2 low cycles); pending peaks at 2 and returns to 0.
- Overflow: PEND_BITS=2, width=20, 5 strobes during HIGH -> pending saturates at 3; overflow pulses one cycle after the 4th and 5th extra strobes; exactly 4 output pulses total.
- Reset mid-pulse: assert reset during cycle 3 of a width=10 pulse -> level_out, busy and pending drop to 0 asynchronously; after deassert, a new strobe gives a full 10-cycle pulse.
- Retrigger (with PULSE_STRETCH_RETRIGGER_EN): width=4, strobes at 10 and 12 -> level_out high 11..16, a single 6-cycle pulse; pending stays 0. Without the macro, the same stimulus gives two 4-cycle pulses: 11..14 and 17..20.
